rle_block_enc: RTL and testbench

RLE_BLOCK_ENC -- requirements
Module: rle_block_enc

---
 rtl/rle_block_enc.sv | 151 +++++++++++++++
 tb/tb_rle_block_enc.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rle_block_enc.sv
// rtl/rle_block_enc.sv - run-length symbol encoder for blocks of zig-zag ordered coefficients
module rle_block_enc #(
  parameter int COEF_W    = 12,
  parameter int BLOCK_LEN = 64,
  parameter int MAX_RUN   = 15,
  localparam int RUN_W    = $clog2(MAX_RUN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_coef,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_kind,
  output logic [RUN_W-1:0]  out_run,
  output logic [COEF_W-1:0] out_value,
  output logic              out_last
);

  localparam int IDX_W  = $clog2(BLOCK_LEN);
  localparam int ZP_RAW = $clog2(BLOCK_LEN / (MAX_RUN + 1) + 1);
  localparam int ZP_W   = (ZP_RAW < 1) ? 1 : ZP_RAW;

  localparam logic [1:0] K_DC  = 2'b00;
  localparam logic [1:0] K_AC  = 2'b01;
  localparam logic [1:0] K_ZRL = 2'b10;
  localparam logic [1:0] K_EOB = 2'b11;

  typedef enum logic {ST_ACCEPT, ST_FLUSH} state_t;

  typedef struct packed {
    logic [1:0]        kind;
    logic [RUN_W-1:0]  run;
    logic [COEF_W-1:0] value;
    logic              last;
  } sym_t;

  state_t            state;
  sym_t              out_sym;
  sym_t              hold_sym;
  logic              hold_sent;
  logic [IDX_W-1:0]  idx;
  logic [RUN_W-1:0]  run_cnt;
  logic [ZP_W-1:0]   zrl_pend;

  logic in_fire;
  logic out_fire;
  logic is_last;
  logic coef_zero;

  function automatic sym_t mk_sym(input logic [1:0] kind, input logic [RUN_W-1:0] run,
                                  input logic [COEF_W-1:0] value, input logic last);
    sym_t s;
    s.kind  = kind;
    s.run   = run;
    s.value = value;
    s.last  = last;
    return s;
  endfunction

  assign in_ready  = (state == ST_ACCEPT) && (!out_valid || out_ready);
  assign in_fire   = in_valid && in_ready && ce;
  assign out_fire  = out_valid && out_ready && ce;
  assign is_last   = (idx == IDX_W'(BLOCK_LEN - 1));
  assign coef_zero = (in_coef == '0);

  assign out_kind  = out_sym.kind;
  assign out_run   = out_sym.run;
  assign out_value = out_sym.value;
  assign out_last  = out_sym.last;

  // Coefficient intake, zero-run counting and symbol generation (including ZRL flush)
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ACCEPT;
      out_valid <= 1'b0;
      out_sym   <= '0;
      hold_sym  <= '0;
      hold_sent <= 1'b0;
      idx       <= '0;
      run_cnt   <= '0;
      zrl_pend  <= '0;
    end else if (ce) begin
      if (out_fire) begin
        out_valid <= 1'b0;
      end
      case (state)
        ST_ACCEPT: begin
          if (in_fire) begin
            if (idx == '0) begin
              out_sym   <= mk_sym(K_DC, '0, in_coef, 1'b0);
              out_valid <= 1'b1;
              idx       <= idx + IDX_W'(1);
            end else begin
              idx <= is_last ? '0 : idx + IDX_W'(1);
              if (coef_zero) begin
                if (is_last) begin
                  // Trailing zeros collapse into EOB; pending runs are dropped
                  out_sym   <= mk_sym(K_EOB, '0, '0, 1'b1);
                  out_valid <= 1'b1;
                  run_cnt   <= '0;
                  zrl_pend  <= '0;
                end else if (run_cnt == RUN_W'(MAX_RUN)) begin
                  run_cnt  <= '0;
                  zrl_pend <= zrl_pend + ZP_W'(1);
                end else begin
                  run_cnt <= run_cnt + RUN_W'(1);
                end
              end else if (zrl_pend == '0) begin
                out_sym   <= mk_sym(K_AC, run_cnt, in_coef, is_last);
                out_valid <= 1'b1;
                run_cnt   <= '0;
              end else begin
                // First ZRL goes out now; the AC symbol waits in the hold register
                hold_sym  <= mk_sym(K_AC, run_cnt, in_coef, is_last);
                hold_sent <= 1'b0;
                out_sym   <= mk_sym(K_ZRL, RUN_W'(MAX_RUN), '0, 1'b0);
                out_valid <= 1'b1;
                zrl_pend  <= zrl_pend - ZP_W'(1);
                run_cnt   <= '0;
                state     <= ST_FLUSH;
              end
            end
          end
        end
        ST_FLUSH: begin
          if (out_fire) begin
            if (zrl_pend != '0) begin
              out_sym   <= mk_sym(K_ZRL, RUN_W'(MAX_RUN), '0, 1'b0);
              out_valid <= 1'b1;
              zrl_pend  <= zrl_pend - ZP_W'(1);
            end else if (!hold_sent) begin
              out_sym   <= hold_sym;
              out_valid <= 1'b1;
              hold_sent <= 1'b1;
            end else begin
              hold_sent <= 1'b0;
              run_cnt   <= '0;
              zrl_pend  <= '0;
              state     <= ST_ACCEPT;
            end
          end
        end
        default: state <= ST_ACCEPT;
      endcase
    end
  end

endmodule

// File: tb/tb_rle_block_enc.sv
// tb/tb_rle_block_enc.sv - scoreboard bench for rle_block_enc
module tb_rle_block_enc;

  localparam int COEF_W = 12;
  localparam int BLEN   = 64;
  localparam int RUN_W  = 4;

  logic              clk;
  logic              rst;
  logic              ce;
  logic              in_valid;
  logic              in_ready;
  logic [COEF_W-1:0] in_coef;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_kind;
  logic [RUN_W-1:0]  out_run;
  logic [COEF_W-1:0] out_value;
  logic              out_last;

  typedef struct {
    logic [1:0]        kind;
    logic [RUN_W-1:0]  run;
    logic [COEF_W-1:0] value;
    logic              last;
  } exp_t;

  exp_t exp_q[$];
  int   blk[BLEN];
  int   checks;
  int   failures;

  rle_block_enc #(.COEF_W(COEF_W), .BLOCK_LEN(BLEN), .MAX_RUN(15)) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_kind(out_kind), .out_run(out_run), .out_value(out_value), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [1:0] k, input int r, input int v, input logic l);
    exp_t e;
    e.kind  = k;
    e.run   = RUN_W'(r);
    e.value = COEF_W'(v);
    e.last  = l;
    return e;
  endfunction

  // Reference model: expected symbols for the block in blk[]
  task automatic push_block();
    int run;
    run = 0;
    exp_q.push_back(mk(2'b00, 0, blk[0], 1'b0));
    for (int i = 1; i < BLEN; i++) begin
      if (blk[i] == 0) begin
        if (i == BLEN - 1) exp_q.push_back(mk(2'b11, 0, 0, 1'b1));
        else run++;
      end else begin
        while (run >= 16) begin
          exp_q.push_back(mk(2'b10, 15, 0, 1'b0));
          run -= 16;
        end
        exp_q.push_back(mk(2'b01, run, blk[i], i == BLEN - 1));
        run = 0;
      end
    end
  endtask

  // One clock: observe at negedge (scoreboard pop on output transfer), return after posedge
  task automatic step(output bit fired);
    exp_t e;
    @(negedge clk);
    fired = in_valid && in_ready && ce && !rst;
    if (!rst && out_valid && out_ready && ce) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_symbol got kind=%0d run=%0d value=%0d last=%0d required none",
                 out_kind, out_run, $signed(out_value), out_last);
      end else begin
        e = exp_q.pop_front();
        if (out_kind !== e.kind || out_run !== e.run || out_value !== e.value || out_last !== e.last) begin
          failures++;
          $display("FAIL symbol got kind=%0d run=%0d value=%0d last=%0d required kind=%0d run=%0d value=%0d last=%0d",
                   out_kind, out_run, $signed(out_value), out_last, e.kind, e.run, $signed(e.value), e.last);
        end
      end
      if (out_kind === 2'b10) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL in_ready_during_zrl got %b required 0", in_ready);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_coefs(input int from, input int to, input bit rand_rdy, input bit rand_ce);
    bit fired;
    int cyc;
    for (int i = from; i <= to; i++) begin
      in_valid = 1'b1;
      in_coef  = COEF_W'(blk[i]);
      fired    = 1'b0;
      cyc      = 0;
      while (!fired && cyc < 500) begin
        step(fired);
        cyc++;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        if (rand_ce) ce = ($urandom_range(0, 3) != 0);
      end
      if (!fired) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout index=%0d got no transfer required transfer", i);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit fired;
    int cyc;
    out_ready = 1'b1;
    ce        = 1'b1;
    cyc       = 0;
    while (exp_q.size() != 0 && cyc < 2000) begin
      step(fired);
      cyc++;
    end
    step(fired);
    step(fired);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_queue got %0d symbols outstanding required 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_out_valid got %b required 0", out_valid);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL %s_out_valid got %b required 0", tag, out_valid); end
    checks++;
    if (out_kind !== 2'b00) begin failures++; $display("FAIL %s_out_kind got %0d required 0", tag, out_kind); end
    checks++;
    if (out_run !== '0) begin failures++; $display("FAIL %s_out_run got %0d required 0", tag, out_run); end
    checks++;
    if (out_value !== '0) begin failures++; $display("FAIL %s_out_value got %0d required 0", tag, out_value); end
    checks++;
    if (out_last !== 1'b0) begin failures++; $display("FAIL %s_out_last got %b required 0", tag, out_last); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL %s_in_ready got %b required 1", tag, in_ready); end
  endtask

  task automatic clear_blk();
    for (int i = 0; i < BLEN; i++) blk[i] = 0;
  endtask

  task automatic test_reset();
    bit fired;
    rst = 1'b1;
    step(fired);
    step(fired);
    rst = 1'b0;
    check_reset_outputs("reset");
  endtask

  task automatic test_dc_ac();
    clear_blk();
    blk[0] = 5;
    blk[1] = 3;
    push_block();
    drive_coefs(0, BLEN - 1, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_zrl_mid();
    clear_blk();
    blk[21] = -2;
    push_block();
    drive_coefs(0, BLEN - 1, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_all_zero();
    clear_blk();
    blk[0] = 9;
    push_block();
    drive_coefs(0, BLEN - 1, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_zrl_last();
    clear_blk();
    blk[0]  = -100;
    blk[63] = 7;
    push_block();
    drive_coefs(0, BLEN - 1, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_stall();
    bit fired;
    logic [1:0]        k0;
    logic [RUN_W-1:0]  r0;
    logic [COEF_W-1:0] v0;
    logic              l0;
    clear_blk();
    blk[0]  = -7;
    blk[5]  = 12;
    blk[40] = -3;
    push_block();
    out_ready = 1'b0;
    drive_coefs(0, 0, 1'b0, 1'b0);
    k0 = out_kind;
    r0 = out_run;
    v0 = out_value;
    l0 = out_last;
    in_valid = 1'b1;
    in_coef  = COEF_W'(blk[1]);
    for (int c = 0; c < 5; c++) begin
      ce = c[0];
      step(fired);
      checks++;
      if (out_valid !== 1'b1 || out_kind !== k0 || out_run !== r0 || out_value !== v0 || out_last !== l0) begin
        failures++;
        $display("FAIL stall_hold cycle=%0d got valid=%b kind=%0d value=%0d required valid=1 kind=%0d value=%0d",
                 c, out_valid, out_kind, $signed(out_value), k0, $signed(v0));
      end
      checks++;
      if (in_ready !== 1'b0 || fired) begin
        failures++;
        $display("FAIL stall_in_ready cycle=%0d got in_ready=%b fired=%b required 0", c, in_ready, fired);
      end
    end
    ce        = 1'b1;
    out_ready = 1'b1;
    drive_coefs(1, BLEN - 1, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_reset_mid();
    bit fired;
    clear_blk();
    for (int i = 0; i <= 10; i++) blk[i] = i + 1;
    exp_q.push_back(mk(2'b00, 0, 1, 1'b0));
    for (int i = 1; i <= 9; i++) exp_q.push_back(mk(2'b01, 0, i + 1, 1'b0));
    drive_coefs(0, 10, 1'b0, 1'b0);
    rst = 1'b1;
    step(fired);
    rst = 1'b0;
    check_reset_outputs("reset_mid");
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_emitted got %0d outstanding required 0", exp_q.size());
      exp_q.delete();
    end
    clear_blk();
    blk[0] = 33;
    blk[2] = -1;
    push_block();
    drive_coefs(0, BLEN - 1, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < BLEN; i++) begin
        if ($urandom_range(0, 3) == 0) blk[i] = int'($urandom_range(0, 200)) - 100;
        else blk[i] = 0;
      end
      if (b == 3) blk[BLEN - 1] = -2048;
      push_block();
      drive_coefs(0, BLEN - 1, 1'b1, 1'b1);
    end
    drain();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    ce        = 1'b1;
    in_valid  = 1'b0;
    in_coef   = '0;
    out_ready = 1'b1;
    test_reset();
    test_dc_ac();
    test_zrl_mid();
    test_all_zero();
    test_zrl_last();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
